// File: rtl/seq_det_pkg.sv
// Shared constants for the parameterised serial sequence detector.
package seq_det_pkg;

  localparam int unsigned SEQ_LEN_MAX = 16;
  localparam int unsigned SEQ_LEN_DEF = 4;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam logic [SEQ_LEN_MAX-1:0] RESET_PATTERN_DEF = 16'b1011;

endpackage : seq_det_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : sat_counter

// File: rtl/param_sequence_detector.sv
// Serial pattern detector with loadable pattern, overlap/non-overlap modes
// and a saturating match counter.
module param_sequence_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned         SEQ_LEN       = SEQ_LEN_DEF,
  parameter int unsigned         CNT_W         = CNT_W_DEF,
  parameter logic [SEQ_LEN-1:0]  RESET_PATTERN = RESET_PATTERN_DEF[SEQ_LEN-1:0]
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dataIn,
  input  logic               validIn,
  input  logic [SEQ_LEN-1:0] patternIn,
  input  logic               patternLoad,
  input  logic               overlapEn,
  input  logic               cntClr,
  output logic               detected,
  output logic [CNT_W-1:0]   matchCount,
  output logic               armed
);

  localparam int unsigned FILL_W = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(SEQ_LEN);

  logic [SEQ_LEN-1:0] history, history_nxt, hist_shift;
  logic [SEQ_LEN-1:0] pattern, pattern_nxt;
  logic [FILL_W-1:0]  fill, fill_nxt, fill_inc;
  logic               match;

  // Candidate shift, compare and next-state selection; load wins over data.
  always_comb begin
    history_nxt = history;
    pattern_nxt = pattern;
    fill_nxt    = fill;
    hist_shift  = {history[SEQ_LEN-2:0], dataIn};
    fill_inc    = (fill == FULL) ? FULL : fill + FILL_W'(1);
    match       = validIn && !patternLoad && (fill_inc == FULL) &&
                  (hist_shift == pattern);

    if (patternLoad) begin
      pattern_nxt = patternIn;
      fill_nxt    = '0;
    end else if (validIn) begin
      history_nxt = hist_shift;
      fill_nxt    = (match && !overlapEn) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history  <= '0;
      fill     <= '0;
      pattern  <= RESET_PATTERN;
      detected <= 1'b0;
      armed    <= 1'b0;
    end else begin
      history  <= history_nxt;
      fill     <= fill_nxt;
      pattern  <= pattern_nxt;
      detected <= match;
      armed    <= (fill_nxt == FULL);
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (match),
    .clr  (cntClr),
    .count(matchCount)
  );

endmodule : param_sequence_detector

// File: tb/tb_param_sequence_detector.sv
// Directed, table-driven bench for param_sequence_detector (default build
// with pattern 1011 plus a CNT_W=2 build with pattern 1111).
module tb_param_sequence_detector;

  logic       clk;
  logic       rst_n;
  logic       dataIn, validIn, patternLoad, overlapEn, cntClr;
  logic [3:0] patternIn;
  logic       det_a, armed_a, det_b, armed_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int errors = 0;
  int checks = 0;

  param_sequence_detector dut_a (
    .clk(clk), .rst_n(rst_n), .dataIn(dataIn), .validIn(validIn),
    .patternIn(patternIn), .patternLoad(patternLoad), .overlapEn(overlapEn),
    .cntClr(cntClr), .detected(det_a), .matchCount(cnt_a), .armed(armed_a)
  );

  param_sequence_detector #(
    .SEQ_LEN(4), .CNT_W(2), .RESET_PATTERN(4'b1111)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .dataIn(dataIn), .validIn(validIn),
    .patternIn(patternIn), .patternLoad(patternLoad), .overlapEn(overlapEn),
    .cntClr(cntClr), .detected(det_b), .matchCount(cnt_b), .armed(armed_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      grp;
    bit         rst;
    logic       valid, data, load, ovl, clr;
    logic [3:0] pat;
    logic       det;
    logic [7:0] cnt;
    logic       armed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string grp, bit rst, logic valid, logic data,
                              logic load, logic ovl, logic clr, logic [3:0] pat,
                              logic det, logic [7:0] cnt, logic armed);
    vec_t v;
    v.grp = grp; v.rst = rst; v.valid = valid; v.data = data; v.load = load;
    v.ovl = ovl; v.clr = clr; v.pat = pat; v.det = det; v.cnt = cnt;
    v.armed = armed;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dataIn = 1'b0; validIn = 1'b0; patternLoad = 1'b0;
    cntClr = 1'b0; patternIn = 4'b1011;
  endtask

  // Assert reset away from the edge, confirm it acts immediately, release.
  task automatic do_reset(string name);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check({name, ".rst_det"},   {7'd0, det_a},   8'd0);
    check({name, ".rst_cnt"},   cnt_a,           8'd0);
    check({name, ".rst_armed"}, {7'd0, armed_a}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(logic valid, logic data, logic load, logic ovl,
                       logic clr, logic [3:0] pat);
    @(negedge clk);
    validIn = valid; dataIn = data; patternLoad = load;
    overlapEn = ovl; cntClr = clr; patternIn = pat;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(vec_t v, int idx);
    string n;
    if (v.rst) do_reset(v.grp);
    drive(v.valid, v.data, v.load, v.ovl, v.clr, v.pat);
    n = $sformatf("%s[%0d]", v.grp, idx);
    check({n, ".det"},   {7'd0, det_a},   {7'd0, v.det});
    check({n, ".cnt"},   cnt_a,           v.cnt);
    check({n, ".armed"}, {7'd0, armed_a}, {7'd0, v.armed});
  endtask

  localparam logic [3:0] P = 4'b1011;

  initial begin
    rst_n = 1'b1;
    overlapEn = 1'b1;
    idle_inputs();

    // overlapping: 1,0,1,1,0,1,1 -> pulses after bits 4 and 7
    vecs.push_back(mk("ovl", 1, 1,1,0,1,0,P, 0,8'd0,0));
    vecs.push_back(mk("ovl", 0, 1,0,0,1,0,P, 0,8'd0,0));
    vecs.push_back(mk("ovl", 0, 1,1,0,1,0,P, 0,8'd0,0));
    vecs.push_back(mk("ovl", 0, 1,1,0,1,0,P, 1,8'd1,1));
    vecs.push_back(mk("ovl", 0, 1,0,0,1,0,P, 0,8'd1,1));
    vecs.push_back(mk("ovl", 0, 1,1,0,1,0,P, 0,8'd1,1));
    vecs.push_back(mk("ovl", 0, 1,1,0,1,0,P, 1,8'd2,1));
    // non-overlapping: same stream -> one pulse, fill restarts
    vecs.push_back(mk("novl", 1, 1,1,0,0,0,P, 0,8'd0,0));
    vecs.push_back(mk("novl", 0, 1,0,0,0,0,P, 0,8'd0,0));
    vecs.push_back(mk("novl", 0, 1,1,0,0,0,P, 0,8'd0,0));
    vecs.push_back(mk("novl", 0, 1,1,0,0,0,P, 1,8'd1,0));
    vecs.push_back(mk("novl", 0, 1,0,0,0,0,P, 0,8'd1,0));
    vecs.push_back(mk("novl", 0, 1,1,0,0,0,P, 0,8'd1,0));
    vecs.push_back(mk("novl", 0, 1,1,0,0,0,P, 0,8'd1,0));
    // valid gaps with junk data on dataIn
    vecs.push_back(mk("gap", 1, 1,1,0,1,0,P, 0,8'd0,0));
    vecs.push_back(mk("gap", 0, 0,1,0,1,0,P, 0,8'd0,0));
    vecs.push_back(mk("gap", 0, 1,0,0,1,0,P, 0,8'd0,0));
    vecs.push_back(mk("gap", 0, 0,1,0,1,0,P, 0,8'd0,0));
    vecs.push_back(mk("gap", 0, 1,1,0,1,0,P, 0,8'd0,0));
    vecs.push_back(mk("gap", 0, 0,0,0,1,0,P, 0,8'd0,0));
    vecs.push_back(mk("gap", 0, 1,1,0,1,0,P, 1,8'd1,1));
    vecs.push_back(mk("gap", 0, 0,1,0,1,0,P, 0,8'd1,1));
    // pattern load 0110 after bits 0,1; bit on the load edge is discarded
    vecs.push_back(mk("load", 1, 1,0,0,1,0,P, 0,8'd0,0));
    vecs.push_back(mk("load", 0, 1,1,0,1,0,P, 0,8'd0,0));
    vecs.push_back(mk("load", 0, 1,1,1,1,0,4'b0110, 0,8'd0,0));
    vecs.push_back(mk("load", 0, 1,0,0,1,0,P, 0,8'd0,0));
    vecs.push_back(mk("load", 0, 1,1,0,1,0,P, 0,8'd0,0));
    vecs.push_back(mk("load", 0, 1,1,0,1,0,P, 0,8'd0,0));
    vecs.push_back(mk("load", 0, 1,0,0,1,0,P, 1,8'd1,1));
    // cntClr on a non-match cycle, then old pattern 1011 no longer matches
    vecs.push_back(mk("load", 0, 1,1,0,1,1,P, 0,8'd0,1));
    vecs.push_back(mk("load", 0, 1,1,0,1,0,P, 0,8'd0,1));

    #2 rst_n = 1'b0;
    #1;
    check("init.det",   {7'd0, det_a},   8'd0);
    check("init.cnt",   cnt_a,           8'd0);
    check("init.armed", {7'd0, armed_a}, 8'd0);
    check("init.cnt_b", {6'd0, cnt_b},   8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // mid-sequence reset discards 1,0,1; detection restarts from empty
    do_reset("midrst");
    drive(1, 1, 0, 1, 0, P);
    drive(1, 0, 0, 1, 0, P);
    drive(1, 1, 0, 1, 0, P);
    do_reset("midrst2");
    drive(1, 1, 0, 1, 0, P);
    check("midrst.det",   {7'd0, det_a},   8'd0);
    check("midrst.cnt",   cnt_a,           8'd0);
    check("midrst.armed", {7'd0, armed_a}, 8'd0);
    drive(1, 0, 0, 1, 0, P);
    drive(1, 1, 0, 1, 0, P);
    drive(1, 1, 0, 1, 0, P);
    check("midrst.restart_det", {7'd0, det_a}, 8'd1);
    check("midrst.restart_cnt", cnt_a,         8'd1);

    // narrow counter on 1111 build: saturates at 3, then clear beats a match
    do_reset("sat");
    for (int k = 1; k <= 8; k++) begin
      drive(1, 1, 0, 1, 0, P);
      check($sformatf("sat[%0d].det_b", k), {7'd0, det_b}, (k >= 4) ? 8'd1 : 8'd0);
      check($sformatf("sat[%0d].cnt_b", k), {6'd0, cnt_b},
            (k < 4) ? 8'd0 : ((k - 3 > 3) ? 8'd3 : 8'(k - 3)));
    end
    drive(1, 1, 0, 1, 1, P);
    check("satclr.det_b",   {7'd0, det_b},   8'd1);
    check("satclr.cnt_b",   {6'd0, cnt_b},   8'd0);
    check("satclr.armed_b", {7'd0, armed_b}, 8'd1);
    drive(1, 1, 0, 1, 0, P);
    check("satpost.cnt_b",  {6'd0, cnt_b},   8'd1);

    idle_inputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_param_sequence_detector
